// File: rtl/account_bank.sv
// account_bank: account store responder for the ATM controller.
// Holds SAVED_ACCOUNTS entries of {password, balance, active} and services one
// request at a time over valid/ready request and response channels.
// Optional feature macro: ACCOUNT_BANK_SAT_DEPOSIT_EN (saturating deposit).
//
// state | meaning
// IDLE  | req_ready high, waiting for a request handshake
// FETCH | addressed entry copied into the working registers
// EXEC  | phase 0: evaluate status/result; phase 1: commit write, raise rsp_valid
// RESP  | rsp_* held stable until rsp_ready
module account_bank #(
  parameter int SAVED_ACCOUNTS       = 10,
  parameter int ACCOUNT_NUMBER_WIDTH = $clog2(SAVED_ACCOUNTS),
  parameter int PASSWORD_WIDTH       = 16,
  parameter int BALANCE_WIDTH        = 16,
  parameter int INIT_BALANCE         = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [2:0]                      req_op,
  input  logic [ACCOUNT_NUMBER_WIDTH-1:0] req_account,
  input  logic [BALANCE_WIDTH-1:0]        req_amount,
  input  logic [PASSWORD_WIDTH-1:0]       req_password,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [2:0]                      rsp_status,
  output logic [BALANCE_WIDTH-1:0]        rsp_balance,
  output logic [PASSWORD_WIDTH-1:0]       rsp_password,
  output logic                            rsp_active
);

  localparam int P = PASSWORD_WIDTH;
  localparam int B = BALANCE_WIDTH;

  localparam logic [2:0] OP_READ = 3'd0, OP_WITHDRAW = 3'd1, OP_DEPOSIT = 3'd2,
                         OP_SET_PW = 3'd3, OP_DEACT = 3'd4;
  localparam logic [2:0] ST_OK = 3'd0, ST_INSUF = 3'd1, ST_INACTIVE = 3'd2,
                         ST_BAD_ACCT = 3'd3, ST_OVERFLOW = 3'd4, ST_BAD_OP = 3'd5;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, RESP} state_t;
  state_t state;

  logic [P-1:0] pw_mem  [SAVED_ACCOUNTS];
  logic [B-1:0] bal_mem [SAVED_ACCOUNTS];
  logic         act_mem [SAVED_ACCOUNTS];

  logic [2:0]                      op_q;
  logic [ACCOUNT_NUMBER_WIDTH-1:0] acct_q;
  logic [B-1:0]                    amt_q;
  logic [P-1:0]                    npw_q;

  logic         wk_bad;
  logic [P-1:0] wk_pw;
  logic [B-1:0] wk_bal;
  logic         wk_act;

  logic         commit;
  logic [2:0]   res_status;
  logic [B-1:0] res_bal;
  logic [P-1:0] res_pw;
  logic         res_act;
  logic         res_write;

  logic [2:0]   ex_status;
  logic [B-1:0] ex_bal;
  logic [P-1:0] ex_pw;
  logic         ex_act;
  logic         ex_write;
  logic [B:0]   dep_sum;

  // Status evaluation in priority order BAD_ACCT > BAD_OP > INACTIVE > op-specific.
  always_comb begin
    ex_status = ST_OK;
    ex_bal    = wk_bal;
    ex_pw     = wk_pw;
    ex_act    = wk_act;
    dep_sum   = {1'b0, wk_bal} + {1'b0, amt_q};
    if (wk_bad) begin
      ex_status = ST_BAD_ACCT;
      ex_bal    = '0;
      ex_pw     = '0;
      ex_act    = 1'b0;
    end else if (op_q > OP_DEACT) begin
      ex_status = ST_BAD_OP;
    end else if (!wk_act && op_q != OP_READ && op_q != OP_DEACT) begin
      ex_status = ST_INACTIVE;
    end else begin
      case (op_q)
        OP_WITHDRAW: begin
          if (amt_q <= wk_bal) ex_bal = wk_bal - amt_q;
          else                 ex_status = ST_INSUF;
        end
        OP_DEPOSIT: begin
          if (!dep_sum[B]) ex_bal = dep_sum[B-1:0];
`ifdef ACCOUNT_BANK_SAT_DEPOSIT_EN
          else             ex_bal = '1;
`else
          else             ex_status = ST_OVERFLOW;
`endif
        end
        OP_SET_PW: ex_pw  = npw_q;
        OP_DEACT:  ex_act = 1'b0;
        default: ;
      endcase
    end
    ex_write = (ex_status == ST_OK) && (op_q != OP_READ);
  end

  // Request sequencing, entry storage and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_status   <= '0;
      rsp_balance  <= '0;
      rsp_password <= '0;
      rsp_active   <= 1'b0;
      op_q         <= '0;
      acct_q       <= '0;
      amt_q        <= '0;
      npw_q        <= '0;
      wk_bad       <= 1'b0;
      wk_pw        <= '0;
      wk_bal       <= '0;
      wk_act       <= 1'b0;
      commit       <= 1'b0;
      res_status   <= '0;
      res_bal      <= '0;
      res_pw       <= '0;
      res_act      <= 1'b0;
      res_write    <= 1'b0;
      for (int i = 0; i < SAVED_ACCOUNTS; i++) begin
        pw_mem[i]  <= P'(i);
        bal_mem[i] <= B'(INIT_BALANCE);
        act_mem[i] <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            acct_q    <= req_account;
            amt_q     <= req_amount;
            npw_q     <= req_password;
            req_ready <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (32'(acct_q) < SAVED_ACCOUNTS) begin
            wk_bad <= 1'b0;
            wk_pw  <= pw_mem[acct_q];
            wk_bal <= bal_mem[acct_q];
            wk_act <= act_mem[acct_q];
          end else begin
            wk_bad <= 1'b1;
            wk_pw  <= '0;
            wk_bal <= '0;
            wk_act <= 1'b0;
          end
          commit <= 1'b0;
          state  <= EXEC;
        end
        EXEC: begin
          if (!commit) begin
            res_status <= ex_status;
            res_bal    <= ex_bal;
            res_pw     <= ex_pw;
            res_act    <= ex_act;
            res_write  <= ex_write;
            commit     <= 1'b1;
          end else begin
            if (res_write) begin
              pw_mem[acct_q]  <= res_pw;
              bal_mem[acct_q] <= res_bal;
              act_mem[acct_q] <= res_act;
            end
            rsp_status   <= res_status;
            rsp_balance  <= res_bal;
            rsp_password <= res_pw;
            rsp_active   <= res_act;
            rsp_valid    <= 1'b1;
            commit       <= 1'b0;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
